// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
//
// Shared definitions for the JK-cell based counters.
//
//   jk_cmd_e         per-cell command (hold / reset / set / toggle)
//   jk_bit_ctl_t     one cell's control bundle: clock enable plus command
//   jk_cmd_to_jk()   maps a command onto the J/K pin pair, returned as {J,K}
//   jk_cmd_from_bit  turns a wanted bit value into a SET or RESET command
//   jk_clamp_value() highest legal count for a given modulus; load values
//                    above it are clamped to it, and the down-count wraps to it
//
// There are no ports, because this file is a package.
// -----------------------------------------------------------------------------
package jk_pkg;

    // Widest counter the cell bank supports.
    localparam int JK_MAX_WIDTH = 16;

    // The encoding matches the J/K truth table, so {J,K} == command bits.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    typedef struct packed {
        logic    ce;
        jk_cmd_e cmd;
    } jk_bit_ctl_t;

    localparam jk_bit_ctl_t JK_CTL_IDLE = '{ce: 1'b0, cmd: JK_HOLD};

    function automatic logic [1:0] jk_cmd_to_jk(input jk_cmd_e cmd);
        logic [1:0] jk;
        unique case (cmd)
            JK_HOLD:   jk = 2'b00;
            JK_RESET:  jk = 2'b01;
            JK_SET:    jk = 2'b10;
            JK_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

    function automatic jk_cmd_e jk_cmd_from_bit(input logic b);
        return b ? JK_SET : JK_RESET;
    endfunction

    function automatic int jk_clamp_value(input int modulus);
        return modulus - 1;
    endfunction

endpackage : jk_pkg

// File: rtl/jk_ff_cell.sv
// -----------------------------------------------------------------------------
// jk_ff_cell
//
// This is a single JK flip-flop with a clock enable. Q and Qbar are held in
// separate registers, so each one is a true registered output.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high (Q=0, Qbar=1)
//   ce    in   clock enable; 0 holds the state whatever J/K are
//   j     in   J input
//   k     in   K input
//   q     out  registered state
//   qbar  out  registered complement of the state
//
// J/K truth table (applies when ce=1): 00 hold, 01 reset, 10 set, 11 toggle.
// -----------------------------------------------------------------------------
module jk_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    // NOTE: state is updated with non-blocking assignments, so every cell in
    // the bank samples the old value of q in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            qbar <= 1'b1;
        end else if (ce) begin
            unique case ({j, k})
                2'b01: begin
                    q    <= 1'b0;
                    qbar <= 1'b1;
                end
                2'b10: begin
                    q    <= 1'b1;
                    qbar <= 1'b0;
                end
                2'b11: begin
                    // On a toggle, the new Qbar is the old Q.
                    q    <= qbar;
                    qbar <= q;
                end
                default: begin
                    q    <= q;
                    qbar <= qbar;
                end
            endcase
        end
    end

endmodule : jk_ff_cell

// File: rtl/jk_sync_counter.sv
// -----------------------------------------------------------------------------
// jk_sync_counter
//
// This is a synchronous modulo-MODULUS up/down counter made from a bank of
// JK flip-flop cells. The top level only works out the J/K/CE command for each
// bit and the terminal count. All state is held in jk_ff_cell instances.
//
// Parameters
//   WIDTH    counter width in bits (1..16)
//   MODULUS  counts run over 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high (q=0, qbar=all-ones)
//   en        in   count enable; one step per cycle when high
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   synchronous parallel load (en/up are ignored)
//   load_val  in   load value; values >= MODULUS are clamped to MODULUS-1
//   q         out  current count (registered)
//   qbar      out  complement of q (registered, taken from the cells)
//   tc        out  terminal count, combinational:
//                  en & (up ? q==MODULUS-1 : q==0)
//
// Priority on each edge: rst > load > en > hold.
//
// Build option
//   JK_CNT_SATURATE_EN  when defined, the counter stops at the terminal
//                       value instead of wrapping. tc still asserts there.
// -----------------------------------------------------------------------------
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(jk_clamp_value(MODULUS));

    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_eff;
    logic [WIDTH-1:0] carry_up;
    logic [WIDTH-1:0] borrow_dn;
    jk_bit_ctl_t      bit_ctl [WIDTH];

    assign at_max   = (q == MAX_VAL);
    assign at_min   = (q == '0);
    assign load_eff = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    assign tc = en & (up ? at_max : at_min);

    // The ripple conditions for the binary count. Bit i toggles going up when
    // all lower bits are 1, and going down when all lower bits are 0.
    always_comb begin
        carry_up     = '0;
        borrow_dn    = '0;
        carry_up[0]  = 1'b1;
        borrow_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry_up[i]  = carry_up[i-1]  &  q[i-1];
            borrow_dn[i] = borrow_dn[i-1] & ~q[i-1];
        end
    end

    // Per-bit command generation.
    //
    // Every branch starts from the idle default, so no latch can be inferred.
    // At the wrap points the natural toggle pattern would leave the legal
    // range whenever MODULUS < 2**WIDTH. In those cases the next value is
    // forced with explicit SET/RESET commands. When MODULUS == 2**WIDTH the
    // forced value is the same as the binary rollover.
    always_comb begin
        // NOTE: every cell command gets a default before any branch, so an
        // uncovered path holds instead of inferring a latch.
        for (int i = 0; i < WIDTH; i++) begin
            bit_ctl[i] = JK_CTL_IDLE;
        end

        if (load) begin
            for (int i = 0; i < WIDTH; i++) begin
                bit_ctl[i].ce  = 1'b1;
                bit_ctl[i].cmd = jk_cmd_from_bit(load_eff[i]);
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef JK_CNT_SATURATE_EN
                    // Stop at the top. The cells keep the idle default.
                    for (int i = 0; i < WIDTH; i++) begin
                        bit_ctl[i] = JK_CTL_IDLE;
                    end
`else
                    // Wrap MODULUS-1 -> 0.
                    for (int i = 0; i < WIDTH; i++) begin
                        bit_ctl[i].ce  = 1'b1;
                        bit_ctl[i].cmd = JK_RESET;
                    end
`endif
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        bit_ctl[i].ce  = carry_up[i];
                        bit_ctl[i].cmd = carry_up[i] ? JK_TOGGLE : JK_HOLD;
                    end
                end
            end else begin
                if (at_min) begin
`ifdef JK_CNT_SATURATE_EN
                    // Stop at zero. The cells keep the idle default.
                    for (int i = 0; i < WIDTH; i++) begin
                        bit_ctl[i] = JK_CTL_IDLE;
                    end
`else
                    // Wrap 0 -> MODULUS-1.
                    for (int i = 0; i < WIDTH; i++) begin
                        bit_ctl[i].ce  = 1'b1;
                        bit_ctl[i].cmd = jk_cmd_from_bit(MAX_VAL[i]);
                    end
`endif
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        bit_ctl[i].ce  = borrow_dn[i];
                        bit_ctl[i].cmd = borrow_dn[i] ? JK_TOGGLE : JK_HOLD;
                    end
                end
            end
        end
    end

    // The cell bank.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic [1:0] jk;

        assign jk = jk_cmd_to_jk(bit_ctl[gi].cmd);

        jk_ff_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .ce   (bit_ctl[gi].ce),
            .j    (jk[1]),
            .k    (jk[0]),
            .q    (q[gi]),
            .qbar (qbar[gi])
        );
    end

endmodule : jk_sync_counter
